// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key codes are row_idx*4 + col_idx.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    // Index of the lowest set bit; only meaningful for one-hot inputs.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else if (v[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running slot counter that raises tick on the last cycle of every
// SCAN_DIV-cycle slot. Also used by the lock's display multiplexer.
module scan_tick_gen #(
    parameter int SCAN_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [CNT_W-1:0] slot_cnt;

    assign tick = (slot_cnt == CNT_W'(SCAN_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_cnt <= '0;
        else if (tick)
            slot_cnt <= '0;
        else
            slot_cnt <= slot_cnt + 1'b1;
    end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// Column-scanning 4x4 keypad reader with press/release debounce; emits a
// one-cycle key_valid with key_code and holds key_held until release.
module keypad_scanner_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_held
);

    state_t           state;
    logic             tick;
    logic [KEY_W-1:0] cand_code;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rel_cnt;
    logic             row_ok;
    logic [KEY_W-1:0] row_code;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Multi-hot rows are rejected outright to avoid ghost keys.
    assign row_ok   = is_onehot(row);
    assign row_code = {onehot_idx(row), onehot_idx(col)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_SCAN;
            col       <= 4'b0001;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            cand_code <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    S_SCAN: begin
                        if (row_ok) begin
                            cand_code <= row_code;
                            if (DEBOUNCE == 1) begin
                                key_code  <= row_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                state     <= S_HELD;
                            end else begin
                                deb_cnt <= CNT_W'(1);
                                state   <= S_DEBOUNCE;
                            end
                        end else begin
                            col <= {col[2:0], col[3]};
                        end
                    end
                    S_DEBOUNCE: begin
                        if (row_ok && (row_code == cand_code)) begin
                            if (deb_cnt == CNT_W'(DEBOUNCE - 1)) begin
                                key_code  <= cand_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                deb_cnt   <= '0;
                                state     <= S_HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                            col     <= {col[2:0], col[3]};
                            state   <= S_SCAN;
                        end
                    end
                    S_HELD: begin
                        // Any activity on the frozen column restarts the release count.
                        if (row == '0) begin
                            if (rel_cnt == CNT_W'(DEBOUNCE - 1)) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                col      <= {col[2:0], col[3]};
                                state    <= S_SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4: SCAN_DIV=4/DEBOUNCE=3 main instance
// plus a DEBOUNCE=1 instance for single-sample acceptance.
module tb_keypad_scanner_4x4;

    logic       clk;
    logic       rst, rst2;
    logic [3:0] row, row2;
    logic [3:0] col, col2;
    logic [3:0] key_code, key_code2;
    logic       key_valid, key_valid2;
    logic       key_held, key_held2;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    keypad_scanner_4x4 #(.SCAN_DIV(4), .DEBOUNCE(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    keypad_scanner_4x4 #(.SCAN_DIV(4), .DEBOUNCE(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .rst       (rst2),
        .row       (row2),
        .col       (col2),
        .key_code  (key_code2),
        .key_valid (key_valid2),
        .key_held  (key_held2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, counting key_valid pulses of the main instance.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        row  = 4'd0;
        row2 = 4'd0;

        // Reset state
        run(10);
        check("rst_col",   8'(col),       8'h1);
        check("rst_valid", 8'(key_valid), 8'h0);
        check("rst_held",  8'(key_held),  8'h0);
        check("rst_code",  8'(key_code),  8'h0);

        // Column rotation every 4 cycles, with wrap (t counts posedges since release)
        rst = 1'b0;
        run(3);  check("scan_t3",  8'(col), 8'h1);
        run(1);  check("scan_t4",  8'(col), 8'h2);
        run(4);  check("scan_t8",  8'(col), 8'h4);
        run(4);  check("scan_t12", 8'(col), 8'h8);
        run(4);  check("scan_wrap", 8'(col), 8'h1);

        // Clean press: row 1 at col 0100 -> code 6
        run(8);  check("press_col", 8'(col), 8'h4);
        row = 4'b0010;
        pulses = 0;
        run(4);  check("press_frozen", 8'(col), 8'h4);
        run(7);  check("press_early", 8'(key_valid), 8'h0);
        run(1);
        check("press_valid", 8'(key_valid), 8'h1);
        check("press_code",  8'(key_code),  8'h6);
        check("press_held",  8'(key_held),  8'h1);
        run(1);  check("press_pulse_end", 8'(key_valid), 8'h0);
        run(12);
        check("press_one_pulse", 8'(pulses),  8'h1);
        check("held_col",        8'(col),     8'h4);
        check("held_still",      8'(key_held), 8'h1);

        // Release: three quiet ticks
        row = 4'd0;
        run(10); check("rel_before", 8'(key_held), 8'h1);
        run(1);
        check("rel_held", 8'(key_held), 8'h0);
        check("rel_col",  8'(col),      8'h8);
        check("rel_code", 8'(key_code), 8'h6);

        // Bounce: one tick of row 2, then nothing
        row = 4'b0100;
        pulses = 0;
        run(4);  check("bounce_frozen", 8'(col), 8'h8);
        row = 4'd0;
        run(4);  check("bounce_resume", 8'(col), 8'h1);
        run(12);
        check("bounce_col",    8'(col),    8'h8);
        check("bounce_nokey",  8'(pulses), 8'h0);

        // Multi-hot rows are never accepted
        row = 4'b0011;
        run(20);
        check("ghost_col",   8'(col),      8'h1);
        check("ghost_nokey", 8'(pulses),   8'h0);
        check("ghost_held",  8'(key_held), 8'h0);

        // Async reset mid-debounce (deb_cnt=2, col frozen at 0010)
        row = 4'd0;
        run(4);  check("mid_col", 8'(col), 8'h2);
        row = 4'b0001;
        run(9);  check("mid_frozen", 8'(col), 8'h2);
        #3 rst = 1'b1;
        #1;
        check("async_col",   8'(col),       8'h1);
        check("async_code",  8'(key_code),  8'h0);
        check("async_held",  8'(key_held),  8'h0);
        check("async_valid", 8'(key_valid), 8'h0);
        run(5);
        check("async_nokey", 8'(pulses), 8'h0);

        // Fresh press after reset: key sits in column 1, row 0 -> code 1
        rst = 1'b0;
        row = 4'd0;
        run(4);  check("fresh_col", 8'(col), 8'h2);
        row = 4'b0001;
        run(11); check("fresh_nokey", 8'(pulses), 8'h0);
        run(1);
        check("fresh_valid", 8'(key_valid), 8'h1);
        check("fresh_code",  8'(key_code),  8'h1);
        row = 4'd0;

        // DEBOUNCE=1: row 3 at col 0001 -> code 12 right after the first tick
        rst2 = 1'b0;
        row2 = 4'b1000;
        run(3);  check("d1_early", 8'(key_valid2), 8'h0);
        run(1);
        check("d1_valid", 8'(key_valid2), 8'h1);
        check("d1_code",  8'(key_code2),  8'hc);
        check("d1_held",  8'(key_held2),  8'h1);
        check("d1_col",   8'(col2),       8'h1);
        run(1);  check("d1_pulse_end", 8'(key_valid2), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
